// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the iterative
// multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULU = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_DIVU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

    function automatic logic is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MUL) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negate, used both to take operand
// magnitudes and to restore result signs after the unsigned core.
module muldiv_negate #(
    parameter int N = 64
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mul/mulu/div/divu unit: shift-add multiplier or restoring divider,
// one bit per cycle on operand magnitudes, with a final sign-fix cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               op_div;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign op_div = is_div(op);
    assign a_neg  = is_signed_op(op) & a[WIDTH-1];
    assign b_neg  = is_signed_op(op) & b[WIDTH-1];

    muldiv_negate #(.N(WIDTH)) u_neg_a (.val_i(a), .neg_i(a_neg), .res_o(a_mag));
    muldiv_negate #(.N(WIDTH)) u_neg_b (.val_i(b), .neg_i(b_neg), .res_o(b_mag));

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {remainder, dividend bits shifting into quotient bits}.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mcand_q};
    assign div_next = rem_diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    muldiv_negate #(.N(2*WIDTH)) u_neg_prod (
        .val_i(acc_q), .neg_i(sa_q ^ sb_q), .res_o(prod_fix));
    muldiv_negate #(.N(WIDTH)) u_neg_quot (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .res_o(quot_fix));
    muldiv_negate #(.N(WIDTH)) u_neg_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .res_o(rem_fix));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d = op_div;
                    dbz_d = 1'b0;
                    if (op_div && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sa_d    = a_neg;
                        sb_d    = b_neg;
                        mcand_d = op_div ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = div_q ? div_next : mul_next;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort never publishes a result, even one computed this cycle.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE) && !flush;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
